mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/cpu_mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 69 ++++++
 rtl/mem_access_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the CPU memory access path:
//   - request size encodings carried on req_size
//   - state enumeration of the mem_access_unit sequencer
//   - legality check for an incoming request (size/alignment/kind)
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // A request is rejected without touching memory when its size code is
    // reserved, it is misaligned for its size, or it is a fetch that is not a
    // plain aligned word read.
    function automatic logic req_illegal(input logic       is_fetch,
                                         input logic       is_write,
                                         input logic [1:0] size,
                                         input logic [1:0] addr_lo);
        logic ill;
        ill = 1'b0;
        if (size == SIZE_ILL)                              ill = 1'b1;
        if ((size == SIZE_HALF) && addr_lo[0])             ill = 1'b1;
        if ((size == SIZE_WORD) && (addr_lo != 2'b00))     ill = 1'b1;
        if (is_fetch && ((size != SIZE_WORD) || is_write)) ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational little-endian lane handling for sub-word accesses.
//   rdata_i     in  32  word read from memory
//   addr_lo_i   in  2   byte offset within the word
//   size_i      in  2   access size (cpu_mem_pkg SIZE_*)
//   unsigned_i  in  1   1 = zero-extend loads, 0 = sign-extend
//   merge_i     in  32  previously read word to be patched by a store
//   wdata_i     in  32  store data, right-aligned
//   load_o      out 32  extracted and extended load value
//   merge_o     out 32  merge_i with the addressed lane replaced by wdata_i
// ---------------------------------------------------------------------------
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] merge_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_o = rdata_i;
        case (size_i)
            SIZE_BYTE: load_o = unsigned_i ? {24'h0, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_o = unsigned_i ? {16'h0, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default:   load_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_o = merge_i;
        case (size_i)
            SIZE_BYTE: begin
                case (addr_lo_i)
                    2'd0:    merge_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    default: merge_o[31:24] = wdata_i[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
                else              merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Sequences one instruction fetch or data load/store at a time against a
// word-wide memory with a combinational read port. Sub-word stores are done
// as read-modify-write. All memory-side and completion outputs are decoded
// from registered state, so an asynchronous reset removes them at once.
//
// Ports
//   clk           in  1       rising-edge clock
//   reset         in  1       asynchronous, active-low
//   req_valid     in  1       request offered
//   req_ready     out 1       unit idle and able to accept
//   req_is_fetch  in  1       1 = fetch into ir, 0 = data access into mdr
//   req_write     in  1       1 = store
//   req_size      in  2       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in  1       zero-extend sub-word loads
//   req_addr      in  ADDR_W  byte address
//   req_wdata     in  32      store data, right-aligned
//   done          out 1       one-cycle completion pulse
//   err           out 1       request was rejected (valid with done)
//   ir            out 32      instruction register
//   mdr           out 32      memory data register
//   mem_addr      out ADDR_W  word-aligned memory address
//   mem_din       out 32      memory write data
//   mem_read      out 1       memory read strobe
//   mem_write     out 1       memory write strobe
//   mem_dout      in  32      memory read data (combinational)
// ---------------------------------------------------------------------------
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_fetch,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       ir,
    output logic [31:0]       mdr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_dout
);

    state_e             state_q, state_d;

    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [31:0]        wdata_q,  wdata_d;
    logic [1:0]         size_q,   size_d;
    logic               uns_q,    uns_d;
    logic               fetch_q,  fetch_d;
    logic               ill_q,    ill_d;
    logic [31:0]        ir_q,     ir_d;
    logic [31:0]        mdr_q,    mdr_d;
    logic [31:0]        merge_q,  merge_d;

    logic               accept;
    logic               req_ill;
    logic [31:0]        load_data;
    logic [31:0]        merge_data;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_ill = req_illegal(req_is_fetch, req_write, req_size, req_addr[1:0]);

    // Load path works on the live memory word; the store path patches the
    // word captured during RMW_RD, so both share one lane unit.
    mem_lane_align u_lane (
        .rdata_i    (mem_dout),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .merge_i    (merge_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merge_o    (merge_data)
    );

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_ill)                          state_d = ST_RESP;
                    else if (req_is_fetch || !req_write)  state_d = ST_READ;
                    else if (req_size == SIZE_WORD)       state_d = ST_WRITE;
                    else                                  state_d = ST_RMW_RD;
                end
            end
            ST_READ:   state_d = ST_RESP;
            ST_WRITE:  state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        fetch_d = fetch_q;
        ill_d   = ill_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        merge_d = merge_q;

        // Request fields are captured only on accept so the requester may
        // change req_* freely while an access is in flight.
        if (accept) begin
            addr_d  = req_addr;
            wdata_d = req_wdata;
            size_d  = req_size;
            uns_d   = req_unsigned;
            fetch_d = req_is_fetch;
            ill_d   = req_ill;
        end

        if (state_q == ST_READ) begin
            if (fetch_q) ir_d  = mem_dout;
            else         mdr_d = load_data;
        end

        if (state_q == ST_RMW_RD) begin
            merge_d = mem_dout;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            fetch_q <= 1'b0;
            ill_q   <= 1'b0;
            ir_q    <= '0;
            mdr_q   <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            fetch_q <= fetch_d;
            ill_q   <= ill_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            merge_q <= merge_d;
        end
    end

    // ---------------- outputs (state-register decode only) ----------------
    always_comb begin
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_READ: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_din   = wdata_q;
            end
            ST_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            ST_RMW_WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_din   = merge_data;
            end
            ST_RESP: begin
                done = 1'b1;
                err  = ill_q;
            end
            default: ;
        endcase
    end

    assign ir  = ir_q;
    assign mdr = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_fetch;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        done;
    logic        err;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_fetch (req_is_fetch),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .done         (done),
        .err          (err),
        .ir           (ir),
        .mdr          (mdr),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory (the world) ----------------
    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    assign mem_dout = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we)         mem[pre_idx] <= pre_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_din;
    end

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [0:63];
    logic [31:0] model_ir;
    logic [31:0] model_mdr;

    typedef struct {
        logic        err;
        logic [31:0] ir;
        logic [31:0] mdr;
        int          lat;
        int          nrd;
        int          nwr;
        logic [5:0]  idx;
        logic [31:0] memw;
        logic [31:0] addr_al;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: applies the access rules to the byte-addressed memory
    // image using plain shifts and masks.
    task automatic model_op(input logic f, input logic w, input logic [1:0] s,
                            input logic u, input logic [31:0] a, input logic [31:0] wd,
                            output exp_t e);
        logic [31:0] word, v, mask;
        int          sh;
        logic        ill;
        e.idx     = a[7:2];
        e.addr_al = a & 32'hFFFF_FFFC;
        word      = ref_mem[e.idx];
        sh        = 8 * int'(a[1:0]);
        ill = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
              || (f && (s != 2'd2 || w));
        e.err = ill;
        e.nrd = 0;
        e.nwr = 0;
        if (ill) begin
            e.lat = 1;
        end else if (f) begin
            model_ir = word;
            e.lat = 2; e.nrd = 1;
        end else if (!w) begin
            v = word >> sh;
            if (s == 2'd0) begin
                v = v & 32'hFF;
                if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (s == 2'd1) begin
                v = v & 32'hFFFF;
                if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
            model_mdr = v;
            e.lat = 2; e.nrd = 1;
        end else if (s == 2'd2) begin
            ref_mem[e.idx] = wd;
            e.lat = 2; e.nwr = 1;
        end else begin
            mask = ((s == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[e.idx] = (word & ~mask) | ((wd << sh) & mask);
            e.lat = 3; e.nrd = 1; e.nwr = 1;
        end
        e.ir   = model_ir;
        e.mdr  = model_mdr;
        e.memw = ref_mem[e.idx];
        e.acc  = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read && mem_write) begin
                n_vec++; n_mis++;
                $display("FAIL rw_both: mem_read and mem_write both 1 at cycle %0d", cyc);
            end
            if (mem_read)  rd_cnt++;
            if (mem_write) wr_cnt++;
            if ((mem_read || mem_write) && exp_q.size() > 0)
                chk("mem_addr", mem_addr, exp_q[0].addr_al);
            if (mem_write && exp_q.size() > 0)
                chk("mem_din", mem_din, exp_q[0].memw);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_done: done=1 expected no completion at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("err",     {31'h0, err}, {31'h0, e.err});
                    chk("ir",      ir,  e.ir);
                    chk("mdr",     mdr, e.mdr);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("rd_cycles", rd_cnt, e.nrd);
                    chk("wr_cycles", wr_cnt, e.nwr);
                    chk("mem_word", mem[e.idx], e.memw);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic poke(input logic [5:0] idx, input logic [31:0] d);
        pre_idx  = idx;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic f, input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input bit hold);
        exp_t e;
        int   t;
        req_is_fetch = f;
        req_write    = w;
        req_size     = s;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_vec++; n_mis++;
            $display("FAIL ready_timeout: req_ready=0 after %0d cycles, required 1", t);
            req_valid = 1'b0;
            return;
        end
        model_op(f, w, s, u, a, wd, e);
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            // Scramble the request bus; the unit must be working from its copy.
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_size  = 2'($urandom_range(0, 3));
            req_write = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] mdr_before;
    logic [31:0] ir_before;

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_is_fetch = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        pre_we       = 1'b0;
        pre_idx      = '0;
        pre_data     = '0;
        model_ir     = '0;
        model_mdr    = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ir",        ir,  32'h0);
        chk("rst_mdr",       mdr, 32'h0);
        chk("rst_done",      {31'h0, done},      32'h0);
        chk("rst_err",       {31'h0, err},       32'h0);
        chk("rst_mem_read",  {31'h0, mem_read},  32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_mem_addr",  mem_addr, 32'h0);
        chk("rst_mem_din",   mem_din,  32'h0);

        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);

        reset = 1'b1;

        // Fetch of a known word; also the first accept right after reset.
        poke(6'd1, 32'h1234_5678);
        mdr_before = mdr;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
        drain();
        chk("fetch_ir",  ir,  32'h1234_5678);
        chk("fetch_mdr", mdr, mdr_before);

        // Signed and unsigned byte loads.
        poke(6'd4, 32'h80FF_7F01);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
        drain();
        chk("lb_signed", mdr, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        drain();
        chk("lbu", mdr, 32'h0000_0080);

        // Half store via read-modify-write.
        poke(6'd8, 32'hAABB_CCDD);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_1234, 1'b0);
        drain();
        chk("sh_merge", mem[8], 32'h1234_CCDD);

        // Misaligned word load is rejected.
        mdr_before = mdr;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 1'b0);
        drain();
        chk("misaligned_mdr", mdr, mdr_before);

        // Back-to-back word loads with req_valid held.
        poke(6'd16, 32'hA1A1_0001);
        poke(6'd17, 32'hB2B2_0002);
        poke(6'd18, 32'hC3C3_0003);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 1'b0);
        drain();
        chk("b2b_mdr", mdr, 32'hC3C3_0003);

        // Randomised mix, including illegal requests and held valid.
        for (int n = 0; n < 300; n++) begin
            logic        f, w, u;
            logic [1:0]  s;
            logic [31:0] a;
            f = ($urandom_range(0, 3) == 0);
            w = f ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            u = 1'($urandom_range(0, 1));
            a = {24'h0, 8'($urandom)};
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'b10) a[1:0] = 2'b00;
                if (s == 2'b01) a[0]   = 1'b0;
            end
            issue(f, w, s, u, a, $urandom, 1'($urandom_range(0, 1)));
            if (!req_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        drain();

        // Reset while the read half of a read-modify-write is in progress.
        begin
            logic [31:0] saved;
            saved = mem[20];
            req_is_fetch = 1'b0;
            req_write    = 1'b1;
            req_size     = 2'b00;
            req_unsigned = 1'b0;
            req_addr     = 32'h51;
            req_wdata    = 32'h0000_005A;
            req_valid    = 1'b1;
            while (!req_ready) @(negedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk("abort_in_rmw_rd", {31'h0, mem_read}, 32'h1);
            reset = 1'b0;
            #1;
            chk("abort_mem_read",  {31'h0, mem_read},  32'h0);
            chk("abort_mem_write", {31'h0, mem_write}, 32'h0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("abort_hold_write", {31'h0, mem_write}, 32'h0);
                chk("abort_hold_done",  {31'h0, done},      32'h0);
            end
            reset = 1'b1;
            model_ir  = '0;
            model_mdr = '0;
            chk("abort_ready",   {31'h0, req_ready}, 32'h1);
            chk("abort_memword", mem[20], saved);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("abort_no_done", {31'h0, done}, 32'h0);
            end
        end

        // Unit is usable again immediately.
        ir_before = ir;
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b0);
        drain();
        chk("post_reset_ir", ir, ir_before);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
